// File: rtl/fsub_axis_responder_if.sv
// AXI4-Stream bundle for the fsub responder: operand channels A and B plus the result channel.
interface fsub_axis_responder_if;
    logic [31:0] fsub_axis_a_tdata;
    logic        fsub_axis_a_tvalid;
    logic        fsub_axis_a_tready;
    logic [31:0] fsub_axis_b_tdata;
    logic        fsub_axis_b_tvalid;
    logic        fsub_axis_b_tready;
    logic [31:0] fsub_axis_result_tdata;
    logic        fsub_axis_result_tvalid;
    logic        fsub_axis_result_tready;

    modport slave (
        input  fsub_axis_a_tdata,
        input  fsub_axis_a_tvalid,
        output fsub_axis_a_tready,
        input  fsub_axis_b_tdata,
        input  fsub_axis_b_tvalid,
        output fsub_axis_b_tready,
        output fsub_axis_result_tdata,
        output fsub_axis_result_tvalid,
        input  fsub_axis_result_tready
    );

    modport master (
        output fsub_axis_a_tdata,
        output fsub_axis_a_tvalid,
        input  fsub_axis_a_tready,
        output fsub_axis_b_tdata,
        output fsub_axis_b_tvalid,
        input  fsub_axis_b_tready,
        input  fsub_axis_result_tdata,
        input  fsub_axis_result_tvalid,
        output fsub_axis_result_tready
    );
endinterface

// File: rtl/fsub_axis_responder.sv
// Binary32 subtractor behind AXI4-Stream handshakes: collects a and b, returns a-b after a
// fixed CALC delay. One operation in flight; denormals flushed, round-to-nearest-even.
module fsub_axis_responder #(
    parameter int CALC_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    fsub_axis_responder_if.slave        axis
);
    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_CALC    = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    localparam int                CNT_W    = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CALC_CYCLES - 1);

    logic [1:0]       state_r, state_n_s;
    logic [CNT_W-1:0] cnt_r, cnt_n_s;
    logic [31:0]      a_r, b_r, res_data_r, res_calc_s;
    logic             a_held_r, b_held_r, a_held_n_s, b_held_n_s;
    logic             a_tready_r, b_tready_r, a_tready_n_s, b_tready_n_s;
    logic             res_valid_r, res_valid_n_s, res_load_s;
    logic             a_hs_s, b_hs_s, res_hs_s;

    // a + (-b) on binary32 with guard/round/sticky alignment and RNE rounding
    function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
        logic              sa, sb, sx, sy;
        logic [7:0]        ea, eb, ex, ey, d;
        logic [22:0]       fa, fb;
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [23:0]       mx, my;
        logic [26:0]       xe, ye, mask;
        logic [27:0]       sum;
        logic [26:0]       nrm;
        logic [4:0]        lz;
        logic              found, round_up;
        logic signed [9:0] er;
        logic [24:0]       rnd;
        logic [22:0]       mant;
        logic [31:0]       res;
        sa = a[31];
        sb = ~b[31];
        ea = a[30:23];
        eb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        sx = 1'b0; sy = 1'b0; ex = 8'd0; ey = 8'd0; d = 8'd0;
        mx = 24'd0; my = 24'd0; xe = 27'd0; ye = 27'd0; mask = 27'd0;
        sum = 28'd0; nrm = 27'd0; lz = 5'd0; found = 1'b0; round_up = 1'b0;
        er = 10'sd0; rnd = 25'd0; mant = 23'd0; res = 32'd0;
        if (a_nan || b_nan) begin
            res = 32'h7FC00000;
        end else if (a_inf && b_inf) begin
            res = (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC00000;
        end else if (a_inf) begin
            res = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            res = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            res = {sa & sb, 31'd0};
        end else if (a_zero) begin
            res = {sb, b[30:0]};
        end else if (b_zero) begin
            res = a;
        end else begin
            if ({ea, fa} >= {eb, fb}) begin
                sx = sa; ex = ea; mx = {1'b1, fa};
                sy = sb; ey = eb; my = {1'b1, fb};
            end else begin
                sx = sb; ex = eb; mx = {1'b1, fb};
                sy = sa; ey = ea; my = {1'b1, fa};
            end
            d  = ex - ey;
            xe = {mx, 3'b000};
            if (d >= 8'd26) begin
                ye = 27'd1;
            end else begin
                mask  = (27'd1 << d) - 27'd1;
                ye    = {my, 3'b000} >> d;
                ye[0] = ye[0] | (({my, 3'b000} & mask) != 27'd0);
            end
            if (sx == sy) begin
                sum = {1'b0, xe} + {1'b0, ye};
            end else begin
                sum = {1'b0, xe} - {1'b0, ye};
            end
            if (sum == 28'd0) begin
                res = 32'd0;
            end else begin
                if (sum[27]) begin
                    nrm = {sum[27:2], sum[1] | sum[0]};
                    er  = $signed({2'b00, ex}) + 10'sd1;
                end else begin
                    for (int i = 26; i >= 0; i--) begin
                        if (!found && !sum[i]) begin
                            lz = lz + 5'd1;
                        end else begin
                            found = 1'b1;
                        end
                    end
                    nrm = sum[26:0] << lz;
                    er  = $signed({2'b00, ex}) - $signed({5'b00000, lz});
                end
                round_up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
                rnd      = {1'b0, nrm[26:3]} + {24'd0, round_up};
                if (rnd[24]) begin
                    er   = er + 10'sd1;
                    mant = rnd[23:1];
                end else begin
                    mant = rnd[22:0];
                end
                if (er >= 10'sd255) begin
                    res = {sx, 8'hFF, 23'd0};
                end else if (er <= 10'sd0) begin
                    res = {sx, 31'd0};
                end else begin
                    res = {sx, er[7:0], mant};
                end
            end
        end
        return res;
    endfunction

    assign a_hs_s     = axis.fsub_axis_a_tvalid & a_tready_r;
    assign b_hs_s     = axis.fsub_axis_b_tvalid & b_tready_r;
    assign res_hs_s   = res_valid_r & axis.fsub_axis_result_tready;
    assign res_calc_s = fp_sub(a_r, b_r);

    assign axis.fsub_axis_a_tready      = a_tready_r;
    assign axis.fsub_axis_b_tready      = b_tready_r;
    assign axis.fsub_axis_result_tdata  = res_data_r;
    assign axis.fsub_axis_result_tvalid = res_valid_r;

    // Next-state, operand-held flags and registered ready generation
    always_comb begin
        state_n_s     = state_r;
        cnt_n_s       = cnt_r;
        a_held_n_s    = a_held_r;
        b_held_n_s    = b_held_r;
        res_valid_n_s = res_valid_r;
        res_load_s    = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                a_held_n_s = a_held_r | a_hs_s;
                b_held_n_s = b_held_r | b_hs_s;
                if (a_held_r && b_held_r) begin
                    state_n_s = ST_CALC;
                    cnt_n_s   = '0;
                end else begin
                    state_n_s = ST_COLLECT;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_n_s     = ST_OUTPUT;
                    res_load_s    = 1'b1;
                    res_valid_n_s = 1'b1;
                end else begin
                    cnt_n_s = cnt_r + CNT_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (res_hs_s) begin
                    state_n_s     = ST_COLLECT;
                    res_valid_n_s = 1'b0;
                    a_held_n_s    = 1'b0;
                    b_held_n_s    = 1'b0;
                end else begin
                    state_n_s = ST_OUTPUT;
                end
            end
            default: begin
                state_n_s     = ST_COLLECT;
                res_valid_n_s = 1'b0;
                a_held_n_s    = 1'b0;
                b_held_n_s    = 1'b0;
            end
        endcase
        a_tready_n_s = (state_n_s == ST_COLLECT) & ~a_held_n_s;
        b_tready_n_s = (state_n_s == ST_COLLECT) & ~b_held_n_s;
    end

    // State, handshake and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_COLLECT;
            cnt_r       <= '0;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            a_held_r    <= 1'b0;
            b_held_r    <= 1'b0;
            a_tready_r  <= 1'b0;
            b_tready_r  <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= 32'd0;
        end else begin
            state_r     <= state_n_s;
            cnt_r       <= cnt_n_s;
            a_held_r    <= a_held_n_s;
            b_held_r    <= b_held_n_s;
            a_tready_r  <= a_tready_n_s;
            b_tready_r  <= b_tready_n_s;
            res_valid_r <= res_valid_n_s;
            if (a_hs_s) begin
                a_r <= axis.fsub_axis_a_tdata;
            end
            if (b_hs_s) begin
                b_r <= axis.fsub_axis_b_tdata;
            end
            if (res_load_s) begin
                res_data_r <= res_calc_s;
            end
        end
    end
endmodule

// File: tb/tb_fsub_axis_responder.sv
// Bench for fsub_axis_responder: directed vectors plus random operands and handshake timing,
// checked against a reference that subtracts in double precision and rounds to binary32.
module tb_fsub_axis_responder;
    localparam int CALC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fsub_axis_responder_if ifc ();

    fsub_axis_responder #(.CALC_CYCLES(CALC)) dut (
        .clk  (clk),
        .rst  (rst),
        .axis (ifc)
    );

    always #5 clk = ~clk;

    logic [31:0] dir_a [7] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                               32'h7F7FFFFF, 32'h80000000, 32'h3F800000};
    logic [31:0] dir_b [7] = '{32'h3F800000, 32'h3F800000, 32'hB3800000, 32'h7F800000,
                               32'hFF7FFFFF, 32'h00000000, 32'h33800000};
    logic [31:0] dir_e [7] = '{32'h40000000, 32'h00000000, 32'h3F800000, 32'h7FC00000,
                               32'h7F800000, 32'h80000000, 32'h3F7FFFFF};
    int          dir_gb [7] = '{0, 4, 0, 0, 0, 0, 1};
    int          dir_rd [7] = '{0, 0, 5, 1, 0, 2, 0};
    logic [31:0] specials [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                  32'h7FC00001, 32'h00400000, 32'h3F800000, 32'h7F7FFFFF};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) begin
            d = {f[31], 63'd0};
        end else if (f[30:23] == 8'hFF) begin
            d = {f[31], 11'h7FF, f[22:0], 29'd0};
        end else begin
            d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] ref_fsub(input logic [31:0] a, input logic [31:0] b);
        real         r;
        logic [63:0] d;
        int          es;
        logic [24:0] q;
        logic [28:0] rem;
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
            return 32'h7FC00000;
        r = f2r(a) - f2r(b);
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF)
            return (d[51:0] != 52'd0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'd0};
        if (d[62:52] == 11'd0)
            return {d[63], 31'd0};
        es  = int'(d[62:52]) - 896;
        q   = {2'b01, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h10000000 || (rem == 29'h10000000 && q[0]))
            q = q + 25'd1;
        if (q[24]) begin
            q  = q >> 1;
            es = es + 1;
        end
        if (es >= 255) return {d[63], 8'hFF, 23'd0};
        if (es <= 0) return {d[63], 31'd0};
        return {d[63], es[7:0], q[22:0]};
    endfunction

    task automatic send_operands(input logic [31:0] a, input logic [31:0] b, input int ga, input int gb);
        bit a_done = 1'b0;
        bit b_done = 1'b0;
        bit hs_a, hs_b;
        int cyc = 0;
        ifc.fsub_axis_a_tdata = a;
        ifc.fsub_axis_b_tdata = b;
        while (!(a_done && b_done) && cyc < 100) begin
            if (a_done) check_val("a_tready_held", {31'd0, ifc.fsub_axis_a_tready}, 32'd0);
            if (b_done) check_val("b_tready_held", {31'd0, ifc.fsub_axis_b_tready}, 32'd0);
            ifc.fsub_axis_a_tvalid = !a_done && (cyc >= ga);
            ifc.fsub_axis_b_tvalid = !b_done && (cyc >= gb);
            hs_a = ifc.fsub_axis_a_tvalid && ifc.fsub_axis_a_tready;
            hs_b = ifc.fsub_axis_b_tvalid && ifc.fsub_axis_b_tready;
            @(posedge clk); #1;
            cyc++;
            if (hs_a) a_done = 1'b1;
            if (hs_b) b_done = 1'b1;
        end
        ifc.fsub_axis_a_tvalid = 1'b0;
        ifc.fsub_axis_b_tvalid = 1'b0;
        check_val("operands_accepted", {31'd0, a_done && b_done}, 32'd1);
    endtask

    task automatic collect_result(input logic [31:0] exp, input int rd);
        int lat = 0;
        ifc.fsub_axis_result_tready = (rd == 0);
        while (!ifc.fsub_axis_result_tvalid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", lat, CALC + 1);
        for (int k = 0; k < rd; k++) begin
            check_val("hold_tdata", ifc.fsub_axis_result_tdata, exp);
            check_val("hold_tvalid", {31'd0, ifc.fsub_axis_result_tvalid}, 32'd1);
            check_val("hold_treadys", {30'd0, ifc.fsub_axis_a_tready, ifc.fsub_axis_b_tready}, 32'd0);
            @(posedge clk); #1;
        end
        ifc.fsub_axis_result_tready = 1'b1;
        check_val("result", ifc.fsub_axis_result_tdata, exp);
        @(posedge clk); #1;
        ifc.fsub_axis_result_tready = 1'b0;
        check_val("tvalid_drop", {31'd0, ifc.fsub_axis_result_tvalid}, 32'd0);
        check_val("treadys_back", {30'd0, ifc.fsub_axis_a_tready, ifc.fsub_axis_b_tready}, 32'd3);
    endtask

    initial begin
        logic [31:0] a, b, e8;
        int          mode;
        ifc.fsub_axis_a_tdata       = 32'd0;
        ifc.fsub_axis_a_tvalid      = 1'b0;
        ifc.fsub_axis_b_tdata       = 32'd0;
        ifc.fsub_axis_b_tvalid      = 1'b0;
        ifc.fsub_axis_result_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_tvalid", {31'd0, ifc.fsub_axis_result_tvalid}, 32'd0);
        check_val("rst_tdata", ifc.fsub_axis_result_tdata, 32'd0);
        check_val("rst_treadys", {30'd0, ifc.fsub_axis_a_tready, ifc.fsub_axis_b_tready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_treadys", {30'd0, ifc.fsub_axis_a_tready, ifc.fsub_axis_b_tready}, 32'd3);

        for (int i = 0; i < 7; i++) begin
            send_operands(dir_a[i], dir_b[i], 0, dir_gb[i]);
            collect_result(dir_e[i], dir_rd[i]);
        end

        // Reset while the operation sits in CALC must drop everything
        send_operands(32'h3F800000, 32'h3F800000, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("calc_rst_tvalid", {31'd0, ifc.fsub_axis_result_tvalid}, 32'd0);
        check_val("calc_rst_treadys", {30'd0, ifc.fsub_axis_a_tready, ifc.fsub_axis_b_tready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("calc_rst_ready", {30'd0, ifc.fsub_axis_a_tready, ifc.fsub_axis_b_tready}, 32'd3);
        repeat (CALC + 3) @(posedge clk);
        #1;
        check_val("calc_rst_no_result", {31'd0, ifc.fsub_axis_result_tvalid}, 32'd0);
        send_operands(32'h40A00000, 32'h40000000, 1, 0);
        collect_result(32'h40400000, 0);

        for (int n = 0; n < 60; n++) begin
            mode = int'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case (mode)
                0: ;
                1: begin
                    e8 = {24'd0, a[30:23]} + $urandom_range(0, 4) - 32'd2;
                    b = {b[31], e8[7:0], b[22:0]};
                end
                2: b = {b[31], a[30:0]};
                default: begin
                    a = specials[$urandom_range(0, 7)];
                    b = specials[$urandom_range(0, 7)];
                end
            endcase
            send_operands(a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            collect_result(ref_fsub(a, b), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
